// File: rtl/register_io_pkg.sv
// rtl/register_io_pkg.sv - shared types and sizing helpers for the serial word loader
//   Provides the loader state encoding and the lane-count / word-width helpers
//   that turn log2 parameters into sizes.
package register_io_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_e;

  // Number of lanes for a log2 lane-count parameter.
  function automatic int lane_count(input int narray);
    return 2 ** narray;
  endfunction

  // Word width in bits for a log2 word-width parameter.
  function automatic int word_width(input int nword);
    return 2 ** nword;
  endfunction

endpackage

// File: rtl/register_in_bit_counter.sv
// rtl/register_in_bit_counter.sv - frame bit counter with clear-over-enable priority
//   clk : rising-edge clock
//   rst : synchronous active-high reset, counter to 0
//   clr : synchronous clear, wins over en
//   en  : increment by one
//   cnt : current count, Nword+1 bits
module bit_counter #(
  parameter int Nword = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clr,
  input  logic           en,
  output logic [Nword:0] cnt
);

  logic [Nword:0] cnt_q;
  logic [Nword:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/register_in.sv
// rtl/register_in.sv - serial-to-parallel word loader, one MSB-first bit per lane
//   clk        : rising-edge clock
//   rst        : synchronous active-high reset, highest priority
//   write_in   : frame enable, data_in sampled every cycle while high
//   data_in    : one serial bit per lane
//   data_ack   : consumer took data_out; only meaningful in HOLD
//   data_out   : assembled words per lane, registered
//   data_valid : data_out holds a complete, unacknowledged frame
//   busy       : loader is not idle
//   overrun    : sticky, bits arrived while a frame was held unacknowledged
module register_in
  import register_io_pkg::*;
#(
  parameter int Narray = 2,
  parameter int Nword  = 3
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              write_in,
  input  logic [lane_count(Narray)-1:0]     data_in,
  input  logic                              data_ack,
  output logic [word_width(Nword)-1:0]      data_out [lane_count(Narray)-1:0],
  output logic                              data_valid,
  output logic                              busy,
  output logic                              overrun
);

  localparam int L = lane_count(Narray);
  localparam int W = word_width(Nword);
  localparam logic [Nword:0] LAST_CNT = (Nword + 1)'(W - 1);

  state_e         state_q, state_d;
  logic           data_valid_q, data_valid_d;
  logic           busy_q, busy_d;
  logic           overrun_q, overrun_d;

  logic           shift_en;   // accept data_in into the shift registers
  logic           load_out;   // data_in completes the frame; publish it
  logic           cnt_clr;
  logic           cnt_en;
  logic [Nword:0] cnt;

  bit_counter #(
    .Nword(Nword)
  ) u_bit_counter (
    .clk(clk),
    .rst(rst),
    .clr(cnt_clr),
    .en (cnt_en),
    .cnt(cnt)
  );

  always_comb begin
    state_d      = state_q;
    data_valid_d = data_valid_q;
    overrun_d    = overrun_q;
    shift_en     = 1'b0;
    load_out     = 1'b0;
    cnt_clr      = 1'b0;
    cnt_en       = 1'b0;

    case (state_q)
      IDLE: begin
        if (write_in) begin
          // Counter is already 0 here, so one increment lands on 1.
          shift_en = 1'b1;
          cnt_en   = 1'b1;
          state_d  = SHIFT;
        end
      end

      SHIFT: begin
        if (!write_in) begin
          // Abort: stale shift contents are flushed by the next full frame.
          cnt_clr = 1'b1;
          state_d = IDLE;
        end else if (cnt == LAST_CNT) begin
          load_out     = 1'b1;
          cnt_clr      = 1'b1;
          data_valid_d = 1'b1;
          state_d      = HOLD;
        end else begin
          shift_en = 1'b1;
          cnt_en   = 1'b1;
        end
      end

      HOLD: begin
        if (data_ack) begin
          data_valid_d = 1'b0;
          if (write_in) begin
            // Gapless restart: this bit is the first of the next frame.
            shift_en = 1'b1;
            cnt_en   = 1'b1;
            state_d  = SHIFT;
          end else begin
            state_d = IDLE;
          end
        end else if (write_in) begin
          // Nowhere to put the bit while the held frame is unconsumed.
          overrun_d = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      data_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      data_valid_q <= data_valid_d;
      busy_q       <= busy_d;
      overrun_q    <= overrun_d;
    end
  end

  for (genvar i = 0; i < L; i++) begin : g_lane
    logic [W-1:0] sreg_q, sreg_d;
    logic [W-1:0] word_q, word_d;
    logic [W-1:0] shifted;

    always_comb begin
      shifted = {sreg_q[W-2:0], data_in[i]};
      sreg_d  = shift_en ? shifted : sreg_q;
      word_d  = load_out ? shifted : word_q;
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        sreg_q <= '0;
        word_q <= '0;
      end else begin
        sreg_q <= sreg_d;
        word_q <= word_d;
      end
    end

    assign data_out[i] = word_q;
  end

  assign data_valid = data_valid_q;
  assign busy       = busy_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_register_in.sv
// tb/tb_register_in.sv - directed self-checking bench for register_in (W=8, L=4)
module tb_register_in;

  logic       clk = 1'b0;
  logic       rst;
  logic       write_in;
  logic [3:0] data_in;
  logic       data_ack;
  logic [7:0] data_out [3:0];
  logic       data_valid;
  logic       busy;
  logic       overrun;

  logic [7:0] fw [4];
  int         n_total = 0;
  int         n_pass  = 0;

  register_in #(
    .Narray(2),
    .Nword (3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .write_in  (write_in),
    .data_in   (data_in),
    .data_ack  (data_ack),
    .data_out  (data_out),
    .data_valid(data_valid),
    .busy      (busy),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present bit index k (0 = MSB) of every lane's word in fw for one cycle.
  task automatic drive_bit(input int k);
    write_in = 1'b1;
    for (int i = 0; i < 4; i++) data_in[i] = fw[i][7-k];
    tick();
  endtask

  task automatic set_fw(input logic [7:0] w0, input logic [7:0] w1,
                        input logic [7:0] w2, input logic [7:0] w3);
    fw[0] = w0;
    fw[1] = w1;
    fw[2] = w2;
    fw[3] = w3;
  endtask

  task automatic idle_in();
    write_in = 1'b0;
    data_in  = 4'h0;
  endtask

  initial begin
    rst      = 1'b1;
    write_in = 1'b0;
    data_in  = 4'h0;
    data_ack = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();

    check("reset_valid",   data_valid,  0);
    check("reset_busy",    busy,        0);
    check("reset_overrun", overrun,     0);
    check("reset_out0",    data_out[0], 8'h00);
    check("reset_out3",    data_out[3], 8'h00);

    // 1: frame decode
    set_fw(8'hB2, 8'hFF, 8'h00, 8'h5A);
    for (int k = 0; k < 7; k++) drive_bit(k);
    check("t1_no_early_valid", data_valid, 0);
    check("t1_busy_mid",       busy,       1);
    drive_bit(7);
    idle_in();
    check("t1_valid", data_valid,  1);
    check("t1_busy",  busy,        1);
    check("t1_out0",  data_out[0], 8'hB2);
    check("t1_out1",  data_out[1], 8'hFF);
    check("t1_out2",  data_out[2], 8'h00);
    check("t1_out3",  data_out[3], 8'h5A);

    // 2: hold, then ack
    for (int c = 0; c < 5; c++) begin
      tick();
      check("t2_hold_valid", data_valid,  1);
      check("t2_hold_out0",  data_out[0], 8'hB2);
    end
    data_ack = 1'b1;
    tick();
    data_ack = 1'b0;
    check("t2_ack_valid", data_valid,  0);
    check("t2_ack_busy",  busy,        0);
    check("t2_ack_out0",  data_out[0], 8'hB2);
    check("t2_ack_out3",  data_out[3], 8'h5A);

    // 3: abort after 5 bits
    set_fw(8'h00, 8'h11, 8'h22, 8'h33);
    for (int k = 0; k < 5; k++) drive_bit(k);
    check("t3_busy_mid", busy, 1);
    idle_in();
    tick();
    check("t3_busy",  busy,        0);
    check("t3_valid", data_valid,  0);
    check("t3_out0",  data_out[0], 8'hB2);
    tick();
    tick();
    tick();
    check("t3_still_no_valid", data_valid, 0);

    // 4: back-to-back frames, ack in the first HOLD cycle
    set_fw(8'hA5, 8'h0F, 8'h81, 8'h3C);
    for (int k = 0; k < 8; k++) drive_bit(k);
    check("t4_valid1", data_valid,  1);
    check("t4_out0_1", data_out[0], 8'hA5);
    check("t4_out1_1", data_out[1], 8'h0F);
    set_fw(8'h3C, 8'hF0, 8'h7E, 8'hC3);
    data_ack = 1'b1;
    drive_bit(0);
    data_ack = 1'b0;
    check("t4_ninth_valid",   data_valid, 0);
    check("t4_ninth_busy",    busy,       1);
    for (int k = 1; k < 7; k++) drive_bit(k);
    check("t4_no_early_valid2", data_valid, 0);
    drive_bit(7);
    idle_in();
    check("t4_valid2",  data_valid,  1);
    check("t4_out0_2",  data_out[0], 8'h3C);
    check("t4_out1_2",  data_out[1], 8'hF0);
    check("t4_out3_2",  data_out[3], 8'hC3);
    check("t4_overrun", overrun,     0);
    data_ack = 1'b1;
    tick();
    data_ack = 1'b0;
    check("t4_done_busy", busy, 0);

    // 5: overrun while holding
    set_fw(8'h96, 8'h96, 8'h96, 8'h96);
    for (int k = 0; k < 8; k++) drive_bit(k);
    check("t5_valid", data_valid, 1);
    check("t5_overrun_pre", overrun, 0);
    set_fw(8'h00, 8'h00, 8'h00, 8'h00);
    drive_bit(0);
    drive_bit(1);
    idle_in();
    check("t5_overrun",   overrun,     1);
    check("t5_out0",      data_out[0], 8'h96);
    check("t5_out2",      data_out[2], 8'h96);
    check("t5_valid_hld", data_valid,  1);
    data_ack = 1'b1;
    tick();
    data_ack = 1'b0;
    check("t5_ack_valid",   data_valid, 0);
    check("t5_ack_overrun", overrun,    1);
    tick();
    check("t5_sticky", overrun, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5_rst_overrun", overrun,     0);
    check("t5_rst_out0",    data_out[0], 8'h00);

    // 6: reset mid-frame, write_in kept high through reset
    set_fw(8'hFF, 8'hFF, 8'hFF, 8'hFF);
    for (int k = 0; k < 4; k++) drive_bit(k);
    check("t6_busy_pre", busy, 1);
    rst      = 1'b1;
    write_in = 1'b1;
    tick();
    rst = 1'b0;
    idle_in();
    check("t6_rst_busy",    busy,        0);
    check("t6_rst_valid",   data_valid,  0);
    check("t6_rst_overrun", overrun,     0);
    check("t6_rst_out1",    data_out[1], 8'h00);
    set_fw(8'hC3, 8'hC3, 8'hC3, 8'hC3);
    for (int k = 0; k < 7; k++) drive_bit(k);
    check("t6_no_early_valid", data_valid, 0);
    drive_bit(7);
    idle_in();
    check("t6_valid", data_valid, 1);
    for (int i = 0; i < 4; i++) check($sformatf("t6_out%0d", i), data_out[i], 8'hC3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/register_in.md
Name: register_in

Overview:
- Serial-to-parallel loader; the write-direction counterpart of the array read-out serializer.
- Receives one serial bit per likelihood array lane, MSB first, and assembles one 2**Nword-bit word per lane.
- Presents the completed words to the array-programming logic with a valid/ack handshake.
- Sits between the off-chip serial input pins and the RRAM array word-write path.

Parameters:
- Narray, 2, log2 of lane count (lanes L = 2**Narray).
- Nword, 3, log2 of word width (W = 2**Nword bits per lane).

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  reset, synchronous, active-high.
- write_in  in  1  frame enable; while high, data_in is sampled every cycle.
- data_in  in  L  one serial bit per lane, MSB first.
- data_ack  in  1  consumer has taken data_out; honoured only in HOLD.
- data_out  out  W x L (unpacked array [L-1:0] of [W-1:0])  assembled words, registered.
- data_valid  out  1  data_out holds a complete, unacknowledged frame.
- busy  out  1  high whenever state != IDLE.
- overrun  out  1  sticky; bits arrived while a frame was held unacknowledged.

Behaviour:
- Clocking and reset:
  - Single clock domain, clk.
  - rst is synchronous, active-high, and has priority over every other input.
  - Reset values: state IDLE, counter 0, shift registers 0, data_out all 0, data_valid 0, busy 0, overrun 0.
  - rst mid-frame discards the partial frame; mid-HOLD it discards the held frame.
- Counter: Nword+1 bits; counts bits captured in the current frame.
- Shift, per lane i: sreg[i] <= {sreg[i][W-2:0], data_in[i]}. The first sampled bit ends up at data_out[i][W-1].
- IDLE state:
  - write_in=1: shift the first bit, counter <= 1, go to SHIFT.
  - Otherwise hold.
  - data_ack is ignored.
- SHIFT state, write_in=1 and counter < W-1: shift, counter++.
- SHIFT state, write_in=1 and counter == W-1 (last bit):
  - data_out[i] <= {sreg[i][W-2:0], data_in[i]}.
  - data_valid <= 1, counter <= 0, go to HOLD.
  - Latency: data_valid rises on the edge that samples the W-th bit, so it is visible in the cycle after that bit was presented.
- SHIFT state, write_in=0 (abort):
  - Discard the partial frame, counter <= 0, go to IDLE.
  - data_out and data_valid are unchanged.
- SHIFT state: data_ack is ignored.
- HOLD state:
  - data_valid=1; data_out is stable.
  - data_ack=1 and write_in=0: data_valid <= 0, go to IDLE.
  - data_ack=1 and write_in=1: data_valid <= 0, shift the first bit of the next frame, counter <= 1, go to SHIFT. This allows gapless back-to-back frames when the consumer acks in the first HOLD cycle.
  - data_ack=0 and write_in=1: the bit is dropped and overrun <= 1. State, data_out and data_valid are unchanged.
- overrun clears only on rst.
- data_out changes only at frame completion or rst.

Decomposition:
- Package register_io_pkg:
  - state enum typedef {IDLE, SHIFT, HOLD}.
  - Localparam functions for L = 2**Narray and W = 2**Nword.
- One sub-module, bit_counter:
  - Ports: clk, rst, clr, en, cnt [Nword:0].
  - Synchronous clear has priority over enable.
- The per-lane shift registers are a generate loop over L in the top module.

Test Plan (defaults, W=8, L=4):
1. Frame decode:
   - Stimulus: after rst, write_in high 8 cycles; lane0 bits 1,0,1,1,0,0,1,0; lane1 all 1; lane2 all 0; lane3 0,1,0,1,1,0,1,0.
   - Response: next cycle data_valid=1, data_out = {8'hB2, 8'hFF, 8'h00, 8'h5A} (lanes 0..3), busy=1.
2. Hold and ack:
   - Stimulus: keep data_ack=0 for 5 cycles with write_in=0, then pulse data_ack.
   - Response: data_valid and data_out stable throughout; data_valid=0 and busy=0 the cycle after the ack; data_out still 8'hB2 on lane0.
3. Abort:
   - Stimulus: write_in high 5 cycles, then low.
   - Response: no data_valid; data_out keeps its previous value; busy=0 one cycle after write_in falls.
4. Back-to-back:
   - Stimulus: write_in high 16 consecutive cycles, lane0 stream 0xA5 then 0x3C; data_ack high in the first HOLD cycle.
   - Response: first valid shows 8'hA5; the 9th bit is accepted; the second valid shows 8'h3C; overrun=0.
5. Overrun:
   - Stimulus: complete a frame, no ack, write_in high 2 more cycles.
   - Response: overrun=1; data_out unchanged; overrun stays 1 after ack and clears only after rst.
6. Reset mid-frame:
   - Stimulus: rst asserted after 4 bits captured.
   - Response: all outputs 0 the next cycle; a following full frame of 8'hC3 decodes correctly on every lane.
